// File: rtl/ed25519_pkg.sv
// ed25519_pkg: field modulus, word/frame geometry and FSM states shared by the point output path.
// OUT_COMPRESS_EN selects the 4-beat compressed frame instead of the 8-beat x-then-y frame.
package ed25519_pkg;
    localparam logic [254:0] Q = {{247{1'b1}}, 8'hED};
    localparam int WORD_W = 64;
`ifdef OUT_COMPRESS_EN
    localparam int N_BEATS = 4;
`else
    localparam int N_BEATS = 8;
`endif
    localparam int IDX_W = $clog2(N_BEATS);
    localparam logic [2:0] LAST_BEAT = 3'(N_BEATS - 1);
    typedef enum logic {S_IDLE, S_SEND} state_t;
endpackage

// File: rtl/canon_mod_q.sv
// canon_mod_q: single conditional subtract of q; inputs are below 2^255 < 2q, so one step suffices.
module canon_mod_q
    import ed25519_pkg::*;
(
    input  logic [254:0] a_i,
    output logic [254:0] c_o
);
    assign c_o = (a_i >= Q) ? a_i - Q : a_i;
endmodule

// File: rtl/point_serializer.sv
// point_serializer: captures a canonicalised affine point and streams it as 64-bit LE words.
// OUT_COMPRESS_EN: emit the 4-beat {x parity, y} encoding instead of the 8-beat x-then-y frame.
module point_serializer
    import ed25519_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [254:0]      i_x,
    input  logic [254:0]      i_y,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [WORD_W-1:0] o_data,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_drop
);
    state_t state_q, state_d;
    logic [2:0] beat_q, beat_d;
    logic [N_BEATS-1:0][WORD_W-1:0] frame_q, frame_d;
    logic drop_q, drop_d;
    logic [254:0] xc, yc;
    logic xfer, last_beat, capture;

    canon_mod_q u_canon_x (.a_i(i_x), .c_o(xc));
    canon_mod_q u_canon_y (.a_i(i_y), .c_o(yc));

    assign o_valid   = state_q == S_SEND;
    assign o_busy    = o_valid;
    assign last_beat = beat_q == LAST_BEAT;
    assign xfer      = o_valid && i_ready;
    assign o_last    = o_valid && last_beat;
    assign o_data    = o_valid ? frame_q[beat_q[IDX_W-1:0]] : '0;
    assign o_drop    = drop_q;
    // A start coinciding with the final transfer chains the next frame without a bubble.
    assign capture   = i_start && (!o_valid || (xfer && last_beat));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        frame_d = frame_q;
        drop_d  = drop_q || (i_start && !capture);
        if (capture) begin
            state_d = S_SEND;
            beat_d  = '0;
`ifdef OUT_COMPRESS_EN
            frame_d = {xc[0], yc};
`else
            frame_d = {1'b0, yc, 1'b0, xc};
`endif
        end else if (xfer) begin
            state_d = last_beat ? S_IDLE : S_SEND;
            beat_d  = last_beat ? 3'd0 : beat_q + 3'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            frame_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            frame_q <= frame_d;
            drop_q  <= drop_d;
        end
    end
endmodule

// File: tb/tb_point_serializer.sv
// tb_point_serializer: scoreboard bench; driver pushes expected words, negedge monitor pops and compares.
module tb_point_serializer;
    import ed25519_pkg::*;

    logic i_clk = 0, i_rst_n = 0, i_start = 0, i_ready = 0;
    logic [254:0] i_x = '0, i_y = '0;
    logic o_valid, o_last, o_busy, o_drop;
    logic [63:0] o_data;

    int checks = 0, errors = 0;
    logic [63:0] exp_q[$];
    bit drop_exp = 0, mon_en = 0, stalled = 0;
    logic [63:0] stall_data;

    point_serializer dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_x(i_x), .i_y(i_y),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last),
        .o_busy(o_busy), .o_drop(o_drop)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [255:0] canon(logic [254:0] v);
        logic [255:0] qv = {1'b0, Q};
        return {1'b0, v} % qv;
    endfunction

    function automatic logic [254:0] rnd255();
        logic [254:0] v = '0;
        int mode = $urandom_range(0, 3);
        for (int i = 0; i < 8; i++) v = (v << 32) | 255'($urandom());
        if (mode == 0) v = Q + 255'(v % 19);
        else if (mode == 1) v = Q - 255'(1 + v % 19);
        return v;
    endfunction

    task automatic push_frame(logic [254:0] x, logic [254:0] y);
        logic [255:0] xc = canon(x), yc = canon(y);
        logic [511:0] f;
`ifdef OUT_COMPRESS_EN
        f = {256'b0, xc[0], yc[254:0]};
`else
        f = {yc, xc};
`endif
        for (int i = 0; i < N_BEATS; i++) exp_q.push_back(f[i*64 +: 64]);
    endtask

    // Inputs are driven 1 time unit after a rising edge; the frame is accepted if nothing is pending
    // or only the last word remains and it transfers on this edge.
    task automatic cycle(bit st, logic [254:0] x, logic [254:0] y, bit rdy);
        bit acc;
        i_start = st; i_x = x; i_y = y; i_ready = rdy;
        acc = st && (exp_q.size() == 0 || (exp_q.size() == 1 && rdy));
        @(posedge i_clk);
        if (acc) push_frame(x, y);
        if (st && !acc) drop_exp = 1;
        #1;
    endtask

    task automatic idle(int n, bit rdy = 1);
        repeat (n) cycle(0, '0, '0, rdy);
    endtask

    always @(negedge i_clk) if (mon_en) begin
        check("valid", 64'(o_valid), 64'(exp_q.size() > 0));
        check("busy", 64'(o_busy), 64'(exp_q.size() > 0));
        check("drop", 64'(o_drop), 64'(drop_exp));
        check("last", 64'(o_last), 64'(o_valid && exp_q.size() == 1));
        if (stalled) check("stall_hold", o_data, stall_data);
        stalled = o_valid && !i_ready;
        stall_data = o_data;
        if (o_valid && i_ready && exp_q.size() > 0) check("data", o_data, exp_q.pop_front());
    end

    initial begin
        bit pat[4] = '{1, 0, 0, 1};
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_valid", 64'(o_valid), 0);
        check("rst_busy", 64'(o_busy), 0);
        check("rst_drop", 64'(o_drop), 0);
        check("rst_data", o_data, 0);
        i_rst_n = 1;
        mon_en = 1;
        cycle(1, 255'h15, 255'h2A, 1);
        idle(9);
        cycle(1, Q + 255'd5, Q - 255'd1, 1);
        idle(9);
        cycle(1, rnd255(), rnd255(), 1);
        for (int i = 0; i < 40; i++) cycle(0, '0, '0, pat[i % 4]);
        cycle(1, 255'h1111, 255'h2222, 1);
        idle(N_BEATS - 1);
        cycle(1, 255'h3333, 255'h4444, 1);
        idle(N_BEATS + 1);
        cycle(1, 255'h5555, 255'h6666, 1);
        idle(2);
        cycle(1, 255'h7777, 255'h8888, 1);
        idle(N_BEATS + 2);
        cycle(1, rnd255(), rnd255(), 1);
        idle(2);
        #2 i_rst_n = 0;
        mon_en = 0;
        #1;
        check("arst_valid", 64'(o_valid), 0);
        check("arst_busy", 64'(o_busy), 0);
        check("arst_drop", 64'(o_drop), 0);
        check("arst_data", o_data, 0);
        exp_q.delete();
        drop_exp = 0;
        stalled = 0;
        @(negedge i_clk);
        #2 i_rst_n = 1;
        @(posedge i_clk);
        #1 mon_en = 1;
        cycle(1, 255'h9999, 255'hAAAA, 1);
        idle(N_BEATS + 1);
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) == 0, rnd255(), rnd255(), $urandom_range(0, 3) != 0);
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) idle(1);
        check("drain", 64'(exp_q.size()), 0);
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
